// File: rtl/adc_xy_pixel_mapper.sv
// ADC X/Y/RGB sample to framebuffer pixel-write mapper: two-stage scale/address pipeline,
// last-write dedup and a small output FIFO. Optional feature: ADC_XY_PIXEL_MAPPER_BLANK_FILTER_EN.
`timescale 1ns/1ps

module adc_xy_pixel_mapper #(
    parameter int ADC_DATA_BITS  = 10,
    parameter int SRAM_ADDR_BITS = 20,
    parameter int PIXEL_BITS     = 12,
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      s_valid,
    input  logic [ADC_DATA_BITS-1:0]  s_x,
    input  logic [ADC_DATA_BITS-1:0]  s_y,
    input  logic                      s_red,
    input  logic                      s_grn,
    input  logic                      s_blu,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [SRAM_ADDR_BITS-1:0] m_addr,
    output logic [PIXEL_BITS-1:0]     m_pixel,
    output logic [15:0]               drop_count
);

    localparam int COLOR_BITS = PIXEL_BITS / 3;
    localparam int X_BITS     = $clog2(H_VISIBLE);
    localparam int Y_BITS     = $clog2(V_VISIBLE);
    localparam int XP_BITS    = ADC_DATA_BITS + X_BITS;
    localparam int YP_BITS    = ADC_DATA_BITS + Y_BITS;
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS   = PTR_BITS + 1;

    logic [XP_BITS-1:0] x_prod;
    logic [YP_BITS-1:0] y_prod;

    logic              s1_valid;
    logic [X_BITS-1:0] s1_px;
    logic [Y_BITS-1:0] s1_py;
    logic              s1_red, s1_grn, s1_blu;

    logic                      s2_valid;
    logic [SRAM_ADDR_BITS-1:0] s2_addr;
    logic [PIXEL_BITS-1:0]     s2_pixel;

    logic                      rec_valid;
    logic [SRAM_ADDR_BITS-1:0] rec_addr;
    logic [PIXEL_BITS-1:0]     rec_pixel;

    logic [SRAM_ADDR_BITS-1:0] fifo_addr  [FIFO_DEPTH];
    logic [PIXEL_BITS-1:0]     fifo_pixel [FIFO_DEPTH];
    logic [PTR_BITS-1:0]       wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]       count;

    logic is_dup, is_full, blanked, push, pop, drop;

    // Product width is sized so the scaled coordinate is simply the upper X_BITS/Y_BITS bits
    assign x_prod = XP_BITS'(s_x) * XP_BITS'(H_VISIBLE);
    assign y_prod = YP_BITS'(s_y) * YP_BITS'(V_VISIBLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_px    <= '0;
            s1_py    <= '0;
            s1_red   <= 1'b0;
            s1_grn   <= 1'b0;
            s1_blu   <= 1'b0;
        end else begin
            s1_valid <= s_valid;
            s1_px    <= x_prod[XP_BITS-1:ADC_DATA_BITS];
            s1_py    <= y_prod[YP_BITS-1:ADC_DATA_BITS];
            s1_red   <= s_red;
            s1_grn   <= s_grn;
            s1_blu   <= s_blu;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_pixel <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_addr  <= SRAM_ADDR_BITS'(s1_py) * SRAM_ADDR_BITS'(H_VISIBLE) + SRAM_ADDR_BITS'(s1_px);
            s2_pixel <= PIXEL_BITS'({{COLOR_BITS{s1_red}}, {COLOR_BITS{s1_grn}}, {COLOR_BITS{s1_blu}}});
        end
    end

`ifdef ADC_XY_PIXEL_MAPPER_BLANK_FILTER_EN
    assign blanked = (s2_pixel == '0);
`else
    assign blanked = 1'b0;
`endif

    // Full uses the registered count, so a same-cycle pop never rescues a push into a full FIFO
    assign is_dup  = rec_valid && (s2_addr == rec_addr) && (s2_pixel == rec_pixel);
    assign is_full = (count == CNT_BITS'(FIFO_DEPTH));
    assign push    = s2_valid && !blanked && !is_dup && !is_full;
    assign drop    = s2_valid && !blanked && !is_dup && is_full;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rec_valid  <= 1'b0;
            rec_addr   <= '0;
            rec_pixel  <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                rec_valid <= 1'b1;
                rec_addr  <= s2_addr;
                rec_pixel <= s2_pixel;
            end
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr[i]  <= '0;
                fifo_pixel[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr]  <= s2_addr;
                fifo_pixel[wr_ptr] <= s2_pixel;
                wr_ptr             <= wr_ptr + PTR_BITS'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            if (push && !pop)
                count <= count + CNT_BITS'(1);
            else if (pop && !push)
                count <= count - CNT_BITS'(1);
        end
    end

    assign m_valid = (count != '0);
    assign m_addr  = fifo_addr[rd_ptr];
    assign m_pixel = fifo_pixel[rd_ptr];

endmodule

// File: tb/tb_adc_xy_pixel_mapper.sv
// Scoreboard bench for adc_xy_pixel_mapper; honours ADC_XY_PIXEL_MAPPER_BLANK_FILTER_EN when defined.
`timescale 1ns/1ps

module tb_adc_xy_pixel_mapper;

    logic        clk;
    logic        reset_n;
    logic        s_valid;
    logic [9:0]  s_x, s_y;
    logic        s_red, s_grn, s_blu;
    logic        m_valid;
    logic        m_ready;
    logic [19:0] m_addr;
    logic [11:0] m_pixel;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;
    int beats = 0;

    logic [31:0] exp_q[$];
    logic        last_valid;
    logic [19:0] last_addr;
    logic [11:0] last_pixel;

    adc_xy_pixel_mapper dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_x        (s_x),
        .s_y        (s_y),
        .s_red      (s_red),
        .s_grn      (s_grn),
        .s_blu      (s_blu),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_addr     (m_addr),
        .m_pixel    (m_pixel),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference scaling and dedup of what the mapper should emit for one sample
    task automatic modelSample(input int x, input int y, input bit r, input bit g, input bit b);
        int px, py;
        logic [19:0] a;
        logic [11:0] p;
        px = (x * 640) / 1024;
        py = (y * 480) / 1024;
        a  = 20'(py * 640 + px);
        p  = {{4{r}}, {4{g}}, {4{b}}};
`ifdef ADC_XY_PIXEL_MAPPER_BLANK_FILTER_EN
        if (p == 12'h000) return;
`endif
        if (last_valid && last_addr == a && last_pixel == p) return;
        exp_q.push_back({p, a});
        last_valid = 1'b1;
        last_addr  = a;
        last_pixel = p;
    endtask

    // Drives one sample for one cycle; caller must be at posedge+1
    task automatic applyStimulus(input int x, input int y, input bit r, input bit g, input bit b, input bit model);
        s_x     = 10'(x);
        s_y     = 10'(y);
        s_red   = r;
        s_grn   = g;
        s_blu   = b;
        s_valid = 1'b1;
        if (model) modelSample(x, y, r, g, b);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
        idle(5);
        checkOutput(tag, 32'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                checkOutput("extra_beat", 32'(m_valid), 0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checkOutput("addr", 32'(m_addr), 32'(e[19:0]));
                checkOutput("pixel", 32'(m_pixel), 32'(e[31:20]));
            end
        end
    end

    initial begin
        int b0;
        logic [19:0] head;
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_x = '0; s_y = '0; s_red = 0; s_grn = 0; s_blu = 0;
        m_ready = 1'b1;
        last_valid = 1'b0; last_addr = '0; last_pixel = '0;
        idle(3);
        reset_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            checkOutput("idle_valid", 32'(m_valid), 0);
            idle(1);
        end
        checkOutput("idle_drop", 32'(drop_count), 0);

        // Single sample latency and value
        applyStimulus(512, 256, 1, 0, 0, 1);
        checkOutput("lat_n1", 32'(m_valid), 0);
        idle(1);
        checkOutput("lat_n2", 32'(m_valid), 0);
        idle(1);
        checkOutput("lat_n3", 32'(m_valid), 1);
        checkOutput("lat_addr", 32'(m_addr), 77120);
        checkOutput("lat_pixel", 32'(m_pixel), 32'h0F00);
        waitDrain("drain_single");

        // Coordinate extremes
        applyStimulus(1023, 1023, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        waitDrain("drain_corners");

        // Back-to-back duplicates, then A-B-A
        b0 = beats;
        for (int i = 0; i < 5; i++) applyStimulus(300, 400, 0, 1, 1, 1);
        waitDrain("drain_dup");
        checkOutput("dup_beats", 32'(beats - b0), 1);
        b0 = beats;
        applyStimulus(700, 100, 1, 1, 0, 1);
        applyStimulus(50, 900, 0, 0, 1, 1);
        applyStimulus(700, 100, 1, 1, 0, 1);
        waitDrain("drain_aba");
        checkOutput("aba_beats", 32'(beats - b0), 3);

        // Stall with FIFO overflow
        m_ready = 1'b0;
        b0 = beats;
        for (int i = 0; i < 10; i++) applyStimulus(100 + i * 40, 200, 1, 0, 1, i < 4);
        idle(4);
        checkOutput("stall_valid", 32'(m_valid), 1);
        checkOutput("stall_drop", 32'(drop_count), 6);
        head = exp_q[0][19:0];
        checkOutput("stall_head_a", 32'(m_addr), 32'(head));
        idle(3);
        checkOutput("stall_head_b", 32'(m_addr), 32'(head));
        m_ready = 1'b1;
        waitDrain("drain_stall");
        checkOutput("stall_beats", 32'(beats - b0), 4);

        // Asynchronous reset with queued entries
        m_ready = 1'b0;
        applyStimulus(10, 10, 1, 0, 0, 1);
        applyStimulus(20, 20, 0, 1, 0, 1);
        applyStimulus(30, 30, 0, 0, 1, 1);
        idle(4);
        checkOutput("pre_rst_valid", 32'(m_valid), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(m_valid), 0);
        checkOutput("rst_drop", 32'(drop_count), 0);
        exp_q.delete();
        last_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_ready = 1'b1;
        b0 = beats;
        applyStimulus(30, 30, 0, 0, 1, 1);
        waitDrain("drain_resend");
        checkOutput("resend_beats", 32'(beats - b0), 1);

        // Blanked beam sample
        b0 = beats;
        applyStimulus(600, 600, 0, 0, 0, 1);
        waitDrain("drain_blank");
`ifdef ADC_XY_PIXEL_MAPPER_BLANK_FILTER_EN
        checkOutput("blank_beats", 32'(beats - b0), 0);
`else
        checkOutput("blank_beats", 32'(beats - b0), 1);
`endif
        checkOutput("blank_drop", 32'(drop_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
